// File: rtl/ula_timing_pkg.sv
// Shared ULA raster timing constants, interrupt FSM states and a range helper.
package ula_timing_pkg;

  localparam int unsigned H_LAST_DEF   = 911;
  localparam int unsigned V_LAST_DEF   = 311;
  localparam int unsigned INT_LEN_DEF  = 64;

  localparam int unsigned HSYNC_FIRST  = 688;
  localparam int unsigned HSYNC_LAST   = 751;
  localparam int unsigned HBLANK_FIRST = 640;
  localparam int unsigned HBLANK_LAST  = 863;
  localparam int unsigned VSYNC_FIRST  = 248;
  localparam int unsigned VSYNC_LAST   = 251;
  localparam int unsigned VBLANK_FIRST = 240;
  localparam int unsigned VBLANK_LAST  = 255;
  localparam int unsigned DISP_W       = 512;
  localparam int unsigned DISP_H       = 192;
  localparam int unsigned INT_LINE     = 248;

  typedef enum logic {
    INT_IDLE   = 1'b0,
    INT_ACTIVE = 1'b1
  } int_state_e;

  function automatic logic in_range(input logic [9:0] v,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ula_video_timing_if.sv
// Raster bus: horizontal count in, line number and decoded video strobes out.
interface ula_video_timing_if;
  logic [9:0] hcnt;
  logic [8:0] vcnt;
  logic       hsync_n;
  logic       vsync_n;
  logic       blank;
  logic       display;
  logic       border;
  logic       int_n;
  logic       flash;

  modport master (
    output hcnt,
    input  vcnt, hsync_n, vsync_n, blank, display, border, int_n, flash
  );

  modport slave (
    input  hcnt,
    output vcnt, hsync_n, vsync_n, blank, display, border, int_n, flash
  );
endinterface

// File: rtl/ula_int_gen.sv
// Frame interrupt pulse: int_n held low for INT_LEN clocks after a start strobe.
module ula_int_gen
  import ula_timing_pkg::*;
#(
  parameter int unsigned INT_LEN = INT_LEN_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic int_n
);

  int_state_e state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       int_n_q, int_n_d;

  // Next state: load INT_LEN-1 on start, count down to zero while active.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INT_IDLE: begin
        if (start) begin
          state_d = INT_ACTIVE;
          cnt_d   = 7'(INT_LEN - 1);
        end
      end
      INT_ACTIVE: begin
        if (cnt_q == '0) begin
          state_d = INT_IDLE;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      default: state_d = INT_IDLE;
    endcase
    int_n_d = (state_d != INT_ACTIVE);
  end

  // State, counter and registered int_n.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INT_IDLE;
      cnt_q   <= '0;
      int_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      int_n_q <= int_n_d;
    end
  end

  assign int_n = int_n_q;

endmodule

// File: rtl/ula_video_timing.sv
// ULA video timing: line counter, sync/blank/display decode, flash and frame interrupt.
module ula_video_timing
  import ula_timing_pkg::*;
#(
  parameter int unsigned H_LAST  = H_LAST_DEF,
  parameter int unsigned V_LAST  = V_LAST_DEF,
  parameter int unsigned INT_LEN = INT_LEN_DEF
) (
  input  logic                clock,
  input  logic                reset,
  ula_video_timing_if.slave   vbus
);

  logic [8:0] vcnt_q, vcnt_d;
  logic [4:0] frame_q, frame_d;
  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;
  logic       blank_q, blank_d;
  logic       display_q, display_d;
  logic       border_q, border_d;
  logic       line_end, frame_end, int_start;
  logic       hblank, vblank;
  logic [9:0] vcnt_w;

  // Line/frame advance and decode of the current hcnt and line.
  always_comb begin
    vcnt_w    = {1'b0, vcnt_q};
    line_end  = (vbus.hcnt == 10'(H_LAST));
    frame_end = line_end && (vcnt_q == 9'(V_LAST));
    int_start = (vbus.hcnt == '0) && (vcnt_q == 9'(INT_LINE));

    vcnt_d  = vcnt_q;
    frame_d = frame_q;
    if (line_end) begin
      vcnt_d = frame_end ? '0 : vcnt_q + 9'd1;
    end
    if (frame_end) begin
      frame_d = frame_q + 5'd1;
    end

    hblank    = in_range(vbus.hcnt, 10'(HBLANK_FIRST), 10'(HBLANK_LAST));
    vblank    = in_range(vcnt_w, 10'(VBLANK_FIRST), 10'(VBLANK_LAST));
    blank_d   = hblank || vblank;
    display_d = (vbus.hcnt < 10'(DISP_W)) && (vcnt_w < 10'(DISP_H));
    border_d  = !blank_d && !display_d;
    hsync_n_d = !in_range(vbus.hcnt, 10'(HSYNC_FIRST), 10'(HSYNC_LAST));
    vsync_n_d = !in_range(vcnt_w, 10'(VSYNC_FIRST), 10'(VSYNC_LAST));
  end

  // Timing registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      vcnt_q    <= '0;
      frame_q   <= '0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      blank_q   <= 1'b0;
      display_q <= 1'b0;
      border_q  <= 1'b0;
    end else begin
      vcnt_q    <= vcnt_d;
      frame_q   <= frame_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      blank_q   <= blank_d;
      display_q <= display_d;
      border_q  <= border_d;
    end
  end

  ula_int_gen #(.INT_LEN(INT_LEN)) u_int_gen (
    .clock (clock),
    .reset (reset),
    .start (int_start),
    .int_n (vbus.int_n)
  );

  assign vbus.vcnt    = vcnt_q;
  assign vbus.hsync_n = hsync_n_q;
  assign vbus.vsync_n = vsync_n_q;
  assign vbus.blank   = blank_q;
  assign vbus.display = display_q;
  assign vbus.border  = border_q;
  assign vbus.flash   = frame_q[4];

endmodule

// File: tb/tb_ula_video_timing.sv
// Scoreboard bench for ula_video_timing against an arithmetic raster model.
module tb_ula_video_timing;

  typedef struct packed {
    logic [8:0] vcnt;
    logic       hsync_n;
    logic       vsync_n;
    logic       blank;
    logic       display;
    logic       border;
    logic       int_n;
    logic       flash;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ula_video_timing_if vif ();

  ula_video_timing #(.H_LAST(911), .V_LAST(311), .INT_LEN(64)) dut (
    .clock (clk),
    .reset (rst),
    .vbus  (vif)
  );

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state: current line, frames since reset, int clocks left.
  int   m_line  = 0;
  int   m_frame = 0;
  int   m_left  = 0;

  task automatic model_step(input bit r, input int h, output exp_t e);
    bit hb, vb;
    if (r) begin
      m_line = 0; m_frame = 0; m_left = 0;
      e = '0;
      e.hsync_n = 1'b1; e.vsync_n = 1'b1; e.int_n = 1'b1;
    end else begin
      hb = (h >= 640) && (h <= 863);
      vb = (m_line >= 240) && (m_line <= 255);
      e.blank   = hb || vb;
      e.display = (h < 512) && (m_line < 192);
      e.border  = !e.blank && !e.display;
      e.hsync_n = !((h >= 688) && (h <= 751));
      e.vsync_n = !((m_line >= 248) && (m_line <= 251));
      if (m_left > 0) m_left--;
      else if (h == 0 && m_line == 248) m_left = 64;
      if (h == 911) begin
        if (m_line == 311) begin m_line = 0; m_frame++; end
        else m_line++;
      end
      e.vcnt  = 9'(m_line);
      e.int_n = (m_left == 0);
      e.flash = ((m_frame % 32) >= 16);
    end
  endtask

  task automatic drive(input bit r, input int h);
    exp_t e;
    @(negedge clk);
    rst = r;
    vif.hcnt = 10'(h);
    model_step(r, h, e);
    q.push_back(e);
  endtask

  function automatic int rnd_not_end();
    int v = int'($urandom_range(0, 1023));
    if (v == 911) v = 912;
    return v;
  endfunction

  task automatic fast_line();
    if ($urandom_range(0, 3) == 0) drive(1'b0, rnd_not_end());
    drive(1'b0, 911);
  endtask

  task automatic full_line();
    for (int h = 0; h <= 911; h++) drive(1'b0, h);
  endtask

  task automatic advance_to(input int line);
    for (int k = 0; k < 400 && m_line != line; k++) fast_line();
  endtask

  function automatic bit is_full(input int l);
    case (l)
      0, 100, 191, 192, 239, 240, 247, 248, 249, 251, 252, 255, 256, 311: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: every clock the DUT presents a full output set; check it.
  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        a = {vif.vcnt, vif.hsync_n, vif.vsync_n, vif.blank, vif.display,
             vif.border, vif.int_n, vif.flash};
        cyc++;
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs cyc=%0d got vcnt=%0d hs=%b vs=%b bl=%b di=%b bo=%b int=%b fl=%b required vcnt=%0d hs=%b vs=%b bl=%b di=%b bo=%b int=%b fl=%b",
                   cyc, a.vcnt, a.hsync_n, a.vsync_n, a.blank, a.display, a.border, a.int_n, a.flash,
                   e.vcnt, e.hsync_n, e.vsync_n, e.blank, e.display, e.border, e.int_n, e.flash);
        end
        total++;
        if ($countones({vif.blank, vif.display, vif.border}) > 1) begin
          bad++;
          $display("FAIL onehot cyc=%0d got bl/di/bo=%b%b%b required at most one high",
                   cyc, vif.blank, vif.display, vif.border);
        end
      end
    end
  end

  // Stimulus.
  initial begin : stim
    vif.hcnt = '0;
    repeat (3) drive(1'b1, int'($urandom_range(0, 1023)));

    // One frame: full sweeps on boundary lines, fast-forward elsewhere.
    for (int l = 0; l < 312; l++) begin
      if (is_full(l)) full_line();
      else fast_line();
    end

    // Fast frames up to frame 32 to walk flash through both phases and back.
    for (int f = 1; f < 32; f++) begin
      for (int l = 0; l < 312; l++) fast_line();
    end
    full_line();

    // Reset mid-frame, then resume with an arbitrary hcnt.
    advance_to(77);
    drive(1'b1, int'($urandom_range(0, 911)));
    drive(1'b0, int'($urandom_range(0, 910)));

    // Out-of-range hcnt held mid-frame.
    advance_to(150);
    repeat (2000) drive(1'b0, 1000);
    full_line();

    // Reset on the 20th low clock of the interrupt pulse.
    advance_to(248);
    for (int h = 0; h < 20; h++) drive(1'b0, h);
    drive(1'b1, 20);
    for (int h = 21; h <= 911; h++) drive(1'b0, h);
    full_line();

    @(negedge clk);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ula_video_timing.md
ULA_VIDEO_TIMING -- requirements
Module: ula_video_timing

Interface
REQ-001 Parameter H_LAST, 911, final value of the incoming horizontal count (912 clocks per line).
REQ-002 Parameter V_LAST, 311, final vertical line number (312 lines per frame).
REQ-003 Parameter INT_LEN, 64, int_n low width in clocks.
REQ-004 clock  in  1  pixel clock, all logic on rising edge; sole clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 hcnt  in  10  horizontal count from the line counter, 0..H_LAST, +1 per clock, wraps to 0.
REQ-007 vcnt  out  9  current line, 0..V_LAST.
REQ-008 hsync_n  out  1  horizontal sync, active low.
REQ-009 vsync_n  out  1  vertical sync, active low.
REQ-010 blank  out  1  high outside visible raster (H or V blanking).
REQ-011 display  out  1  high inside 256x192 pixel window.
REQ-012 border  out  1  high when visible but not display.
REQ-013 int_n  out  1  CPU frame interrupt, active low.
REQ-014 flash  out  1  attribute flash phase.

Function
REQ-015 vcnt SHALL increment on the clock edge where hcnt==H_LAST; at V_LAST it SHALL wrap to 0; otherwise hold.
REQ-016 hcnt values above H_LAST SHALL never advance vcnt (vcnt holds).
REQ-017 All outputs except vcnt SHALL be registered, decoded from the current hcnt and vcnt, one clock latency from hcnt.
REQ-018 hsync_n SHALL be low for hcnt in 688..751 inclusive (64 clocks).
REQ-019 vsync_n SHALL be low for vcnt in 248..251 inclusive (whole lines).
REQ-020 H blank = hcnt in 640..863; V blank = vcnt in 240..255; blank = H blank OR V blank.
REQ-021 display SHALL be high for hcnt<512 AND vcnt<192; border = NOT blank AND NOT display; display and blank mutually exclusive.
REQ-022 Interrupt FSM states IDLE, ACTIVE: IDLE->ACTIVE on hcnt==0 AND vcnt==248; ACTIVE holds for exactly INT_LEN clocks via 7-bit down-counter, then ->IDLE.
REQ-023 int_n SHALL be low exactly while FSM is ACTIVE (first low cycle one clock after hcnt==0 observed); one pulse per frame.
REQ-024 A 5-bit frame counter SHALL increment when vcnt wraps V_LAST->0; flash = bit 4 (toggles every 16 frames); counter wraps 31->0.
REQ-025 Simultaneous line-end and frame-end (hcnt==H_LAST, vcnt==V_LAST): vcnt->0 and frame counter increment in the same edge.

Reset
REQ-026 While reset high at a clock edge: vcnt=0, frame counter=0, FSM=IDLE, int counter=0, hsync_n=1, vsync_n=1, blank=0, display=0, border=0, int_n=1, flash=0.
REQ-027 Reset mid-frame or mid-interrupt SHALL abort the pulse (int_n=1 next edge); timing resumes from vcnt=0 with current hcnt on first edge after release.
REQ-028 No output SHALL depend on hcnt history prior to reset release.

Structure
REQ-029 Timing constants (sync/blank/display boundaries, INT line, H_LAST, V_LAST) SHALL live in shared package ula_timing_pkg, also used by the line counter.
REQ-030 Interrupt pulse generator SHALL be one sub-module ula_int_gen (start strobe in, int_n out); rest flat.

Verification
REQ-031 Reset, then drive hcnt 0..911 repeatedly for 312 lines -> vcnt steps 0..311, returns to 0 after line 311, hcnt==911.
REQ-032 Line 100, sweep hcnt -> hsync_n low for hcnt 688..751 (sampled one clock later), exactly 64 low clocks per line.
REQ-033 Full frame -> vsync_n low during lines 248..251 only (4x912=3648 clocks); display high for 192x512 clocks total; border/display/blank one-hot-or-zero every cycle.
REQ-034 Frame with INT_LEN=64 -> int_n low exactly 64 clocks starting one clock after (hcnt=0, vcnt=248); assert reset at 20th low clock -> int_n=1 next edge, vcnt=0.
REQ-035 Run 32 frames from reset -> flash 0 frames 0..15, 1 frames 16..31, 0 at frame 32.
REQ-036 Hold hcnt=1000 for 2000 clocks mid-frame -> vcnt unchanged, no int_n pulse.
